regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file for the pipeline ID stage.
//  - One synchronous write port, driven by write-back.
//  - NUM_RD combinational read ports: operand A, operand B, store data, ...
//  - After reset, an init sequencer clears the array one entry per cycle
//    and holds init_busy high until the sweep completes.
//  - Optional same-cycle write-to-read bypass; removes the WB->ID hazard.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W     5  register address width
//  NUM_REGS  32  implemented registers; NUM_REGS <= 2**ADDR_W, NUM_REGS >= 2
//  NUM_RD     3  number of read ports (>= 1)
// PORTS
//  clk       in   1              clock, rising edge
//  rst       in   1              reset, synchronous, active-high
//  we        in   1              write enable
//  waddr     in   ADDR_W         write address
//  wdata     in   DATA_W         write data
//  re        in   NUM_RD         per-port read enable; bit k = port k
//  raddr     in   NUM_RD*ADDR_W  read addresses; port k = [k*ADDR_W +: ADDR_W]
//  rdata     out  NUM_RD*DATA_W  read data; port k = [k*DATA_W +: DATA_W]
//  init_busy out  1              high while clear sweep is running
//  wr_err    out  1              1-cycle pulse: write rejected (range/busy)
// BEHAVIOUR
//  - FSM states: INIT, RUN.
//  - rst sampled high at a posedge: state<=INIT, ptr<=0, init_busy<=1,
//    wr_err<=0. Array contents are not reset directly.
//  - INIT:
//    - Each cycle: mem[ptr]<=0, ptr<=ptr+1.
//    - After clearing ptr==NUM_REGS-1: state<=RUN, init_busy<=0.
//    - init_busy is therefore high for exactly NUM_REGS cycles after the
//      last rst cycle.
//    - rst reasserted mid-INIT restarts the sweep at ptr=0.
//    - we=1 in INIT: no write; wr_err=1 next cycle.
//  - RUN:
//    - we=1 and waddr<NUM_REGS: mem[waddr]<=wdata at posedge.
//    - we=1 and waddr>=NUM_REGS: no write; wr_err=1 next cycle.
//    - wr_err is registered and high for 1 cycle per rejected write.
//  - Read port k, combinational, 0 latency:
//    - rdata_k = 0 if rst, init_busy, !re[k], or raddr_k>=NUM_REGS.
//    - Otherwise rdata_k = mem[raddr_k].
//    - Multiple ports may read the same address in the same cycle.
//  - Read-during-write to the same address: see CONFIGURATION.
//  - Reset values: rdata=0 (forced while rst), init_busy=1, wr_err=0.
//  - Array: NUM_REGS x DATA_W flops, no reset term, single write port.
// CONFIGURATION
//  - REGFILE_BYPASS_EN defined:
//    - In RUN, if we=1, waddr<NUM_REGS, re[k]=1 and raddr_k==waddr,
//      then rdata_k=wdata in the same cycle.
//    - Applies per port independently.
//  - REGFILE_BYPASS_EN undefined:
//    - rdata_k returns the old mem value in the write cycle.
//    - The new value is visible from the next cycle.
//    - The pipeline resolves the hazard with a stall.
// TESTING
//  1 Reset/init: rst 2 cycles ->
//    - init_busy=1 for exactly 32 cycles, then 0.
//    - All rdata=0 throughout.
//    - Reading all 32 regs afterwards returns 0.
//  2 Basic write/read: we, waddr=5, wdata=0xDEADBEEF; next cycle raddr0=5,
//    raddr2=5, re=3'b101 -> rdata0=rdata2=0xDEADBEEF, rdata1=0.
//  3 Bypass: mem[7]=0x11; same cycle we, waddr=7, wdata=0x22, raddr1=7 ->
//    - Defined: rdata1=0x22.
//    - Undefined: rdata1=0x11, then 0x22 next cycle.
//  4 Rejects:
//    - we during INIT -> wr_err pulse 1 cycle, mem unchanged.
//    - NUM_REGS=24, we with waddr=30 -> wr_err pulse, reg 30&31 reads give 0.
//  5 Reset mid-sweep: rst at INIT cycle 10 ->
//    - Sweep restarts; init_busy=1 for a further 32 cycles.
//    - Data written before the reset reads 0.
//  6 Params: DATA_W=64, NUM_RD=4 -> back-to-back writes to regs 0..31, then
//    per-port reads of all regs match the written values.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a post-reset clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     init_busy,
    output logic                     wr_err
);
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                init_busy_q, init_busy_d;
    logic                wr_err_q, wr_err_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_q [NUM_REGS];

    logic                waddr_ok;

    assign waddr_ok = ({1'b0, waddr} < REG_LIMIT);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_busy_d = init_busy_q;
        wr_err_d    = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = waddr;
        mem_wdata   = wdata;
        if (rst) begin
            state_d     = ST_INIT;
            ptr_d       = '0;
            init_busy_d = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // The sweep owns the single write port; external writes are refused.
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = '0;
                    ptr_d     = ptr_q + 1'b1;
                    wr_err_d  = we;
                    if (ptr_q == LAST_PTR) begin
                        state_d     = ST_RUN;
                        init_busy_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (we) begin
                        if (waddr_ok) begin
                            mem_we = 1'b1;
                        end else begin
                            wr_err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d     = ST_INIT;
                    ptr_d       = '0;
                    init_busy_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        ptr_q       <= ptr_d;
        init_busy_q <= init_busy_d;
        wr_err_q    <= wr_err_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              ra_ok;
            logic [DATA_W-1:0] rd;

            assign ra    = raddr[gi*ADDR_W +: ADDR_W];
            assign ra_ok = ({1'b0, ra} < REG_LIMIT);

            always_comb begin
                rd = '0;
                if (!rst && !init_busy_q && re[gi] && ra_ok) begin
                    rd = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
                    if (we && waddr_ok && (ra == waddr)) begin
                        rd = wdata;
                    end
`endif
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = rd;
        end
    endgenerate

    assign init_busy = init_busy_q;
    assign wr_err    = wr_err_q;

endmodule
